// File: rtl/maria_pkg.sv
// maria_pkg: shared types and header field positions for the display-list walker
package maria_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_HDR4, S_CLR, S_IPTR, S_GFX, S_LATCH, S_DONE
  } dl_state_t;
  localparam int HDR_PAL_MSB = 7;
  localparam int HDR_PAL_LSB = 5;
  localparam int HDR_WM_BIT  = 7;
  localparam int HDR_IND_BIT = 5;
  localparam logic [7:0] END_BYTE = 8'h00;
endpackage

// File: rtl/maria_dl_hdr_decode.sv
// maria_dl_hdr_decode: classifies a header's second byte and turns its width field into a byte count
module maria_dl_hdr_decode
  import maria_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_end,
  output logic       o_five,
  output logic [5:0] o_count
);
  logic [4:0] w_neg;
  assign w_neg   = (~i_byte[4:0]) + 5'd1;
  assign o_end   = i_byte == END_BYTE;
  assign o_five  = (i_byte[4:0] == 5'd0) && !o_end;
  // a zero width field only reaches here from a 5-byte header and means a full 32 bytes
  assign o_count = {i_byte[4:0] == 5'd0, w_neg};
endmodule

// File: rtl/maria_dl_fetch.sv
// maria_dl_fetch: per-zone display-list DMA walker feeding the line-buffer write port
module maria_dl_fetch
  import maria_pkg::*;
#(
  parameter int MAX_OBJ = 64
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        mclk0,
  input  logic        dl_start,
  input  logic [15:0] dl_addr,
  input  logic [3:0]  zone_offset,
  input  logic [7:0]  charbase,
  input  logic        cwidth,
  input  logic        dl_abort,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  hpos,
  output logic [2:0]  PALETTE,
  output logic [7:0]  PIXELS,
  output logic        WM,
  output logic        latch_byte,
  output logic        clear_hpos,
  output logic        dl_busy,
  output logic        dl_done
);
  localparam int OW = $clog2(MAX_OBJ + 1);
  dl_state_t   r_state;
  logic [15:0] r_ptr;
  logic [7:0]  r_lo, r_hi, r_hp, r_cptr;
  logic [2:0]  r_pal;
  logic [5:0]  r_cnt, r_i;
  logic        r_ind, r_five, r_sub;
  logic [OW-1:0] r_obj;
  logic        w_ack, w_end, w_five, w_last, w_guard;
  logic [5:0]  w_count, w_ni;
  logic [7:0]  w_cpage;
  logic [15:0] w_gbase, w_dir, w_iptr;
  maria_dl_hdr_decode u_dec (
    .i_byte (mem_data),
    .o_end  (w_end),
    .o_five (w_five),
    .o_count(w_count)
  );
  assign w_ack   = mem_rd & mem_ack;
  assign w_ni    = r_i + 6'd1;
  assign w_last  = w_ni == r_cnt;
  assign w_guard = r_obj == OW'(MAX_OBJ);
  assign w_gbase = {r_hi + {4'h0, zone_offset}, r_lo};
  assign w_dir   = w_gbase + {10'd0, w_ni};
  assign w_iptr  = {r_hi, r_lo} + {10'd0, w_ni};
  assign w_cpage = charbase + {4'h0, zone_offset};
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_ptr <= '0; r_lo <= '0; r_hi <= '0; r_hp <= '0; r_cptr <= '0; r_pal <= '0;
      r_cnt <= '0; r_i <= '0; r_ind <= 1'b0; r_five <= 1'b0; r_sub <= 1'b0; r_obj <= '0;
      mem_addr <= '0; mem_rd <= 1'b0; hpos <= '0; PALETTE <= '0; PIXELS <= '0; WM <= 1'b0;
      latch_byte <= 1'b0; clear_hpos <= 1'b0; dl_busy <= 1'b0; dl_done <= 1'b0;
    end else if (mclk0) begin
      latch_byte <= 1'b0;
      clear_hpos <= 1'b0;
      dl_done    <= 1'b0;
      // DONE already ends the walk, so an abort held there must not re-enter it
      if (dl_abort && r_state != S_IDLE && r_state != S_DONE) begin
        mem_rd  <= 1'b0;
        r_state <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE: if (dl_start) begin
            r_ptr <= dl_addr; r_obj <= '0; mem_addr <= dl_addr; mem_rd <= 1'b1;
            dl_busy <= 1'b1; r_state <= S_HDR0;
          end
          S_HDR0: if (w_ack) begin
            r_lo <= mem_data; r_ptr <= r_ptr + 16'd1; mem_addr <= r_ptr + 16'd1; r_state <= S_HDR1;
          end
          S_HDR1: if (w_ack) begin
            if (w_end) begin
              mem_rd <= 1'b0; r_state <= S_DONE;
            end else begin
              r_five <= w_five;
              r_ind  <= w_five & mem_data[HDR_IND_BIT];
              if (w_five) WM <= mem_data[HDR_WM_BIT];
              else begin
                r_pal <= mem_data[HDR_PAL_MSB:HDR_PAL_LSB]; r_cnt <= w_count;
              end
              r_ptr <= r_ptr + 16'd1; mem_addr <= r_ptr + 16'd1; r_state <= S_HDR2;
            end
          end
          S_HDR2: if (w_ack) begin
            r_hi <= mem_data; r_ptr <= r_ptr + 16'd1; mem_addr <= r_ptr + 16'd1; r_state <= S_HDR3;
          end
          S_HDR3: if (w_ack) begin
            r_ptr <= r_ptr + 16'd1;
            if (r_five) begin
              r_pal <= mem_data[HDR_PAL_MSB:HDR_PAL_LSB]; r_cnt <= w_count;
              mem_addr <= r_ptr + 16'd1; r_state <= S_HDR4;
            end else begin
              r_hp <= mem_data; mem_rd <= 1'b0; r_state <= S_CLR;
            end
          end
          S_HDR4: if (w_ack) begin
            r_hp <= mem_data; r_ptr <= r_ptr + 16'd1; mem_rd <= 1'b0; r_state <= S_CLR;
          end
          S_CLR: begin
            clear_hpos <= 1'b1; hpos <= r_hp; PALETTE <= r_pal; r_obj <= r_obj + OW'(1);
            r_i <= '0; r_sub <= 1'b0; mem_rd <= 1'b1;
            mem_addr <= r_ind ? {r_hi, r_lo} : w_gbase;
            r_state  <= r_ind ? S_IPTR : S_GFX;
          end
          S_IPTR: if (w_ack) begin
            r_cptr <= mem_data; mem_addr <= {w_cpage, mem_data}; r_state <= S_GFX;
          end
          S_GFX: if (w_ack) begin
            PIXELS <= mem_data; latch_byte <= 1'b1; mem_rd <= 1'b0; r_state <= S_LATCH;
          end
          S_LATCH: begin
            // second byte of a wide char stays within the charbase page
            if (r_ind && cwidth && !r_sub) begin
              r_sub <= 1'b1; mem_rd <= 1'b1; mem_addr <= {w_cpage, r_cptr + 8'd1}; r_state <= S_GFX;
            end else if (w_last) begin
              if (w_guard) r_state <= S_DONE;
              else begin
                mem_rd <= 1'b1; mem_addr <= r_ptr; r_state <= S_HDR0;
              end
            end else begin
              r_i <= w_ni; r_sub <= 1'b0; mem_rd <= 1'b1;
              mem_addr <= r_ind ? w_iptr : w_dir;
              r_state  <= r_ind ? S_IPTR : S_GFX;
            end
          end
          S_DONE: begin
            dl_done <= 1'b1; dl_busy <= 1'b0; r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_maria_dl_fetch.sv
// tb_maria_dl_fetch: directed display lists against a byte-array memory, scoreboarded line-buffer events
module tb_maria_dl_fetch;
  logic        clk_sys = 0, RESET_N = 0, mclk0 = 0, dl_start = 0, cwidth = 0, dl_abort = 0;
  logic [15:0] dl_addr = 0;
  logic [3:0]  zone_offset = 0;
  logic [7:0]  charbase = 0;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_ack = 0;
  logic [7:0]  mem_data = 0;
  logic [7:0]  hpos, PIXELS;
  logic [2:0]  PALETTE;
  logic        WM, latch_byte, clear_hpos, dl_busy, dl_done;

  maria_dl_fetch #(.MAX_OBJ(64)) dut (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .mclk0(mclk0), .dl_start(dl_start), .dl_addr(dl_addr),
    .zone_offset(zone_offset), .charbase(charbase), .cwidth(cwidth), .dl_abort(dl_abort),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .hpos(hpos), .PALETTE(PALETTE), .PIXELS(PIXELS), .WM(WM), .latch_byte(latch_byte),
    .clear_hpos(clear_hpos), .dl_busy(dl_busy), .dl_done(dl_done)
  );

  typedef struct {int kind; int a; int b;} ev_t;
  localparam int EV_CLR = 0, EV_LAT = 1, EV_DONE = 2;
  ev_t q[$];
  logic [7:0] mem [0:65535];
  logic [16:0] hold_addr = 17'h10000;
  int checks = 0, errors = 0, clr_seen = 0, done_seen = 0, wcnt = 0;
  bit mon_en = 1;
  int exp_wm = 0;

  always #5 clk_sys = ~clk_sys;
  always begin
    @(negedge clk_sys);
    mclk0 = ~mclk0;
  end

  // memory: variable wait states, stray acks while idle, optional stall on one address
  always begin
    @(negedge clk_sys);
    #2;
    if (mclk0 && mem_rd && ({1'b0, mem_addr} != hold_addr)) begin
      if (wcnt == 0) begin
        mem_ack = 1; mem_data = mem[mem_addr]; wcnt = $urandom_range(0, 2);
      end else begin
        mem_ack = 0; wcnt--;
      end
    end else if (mclk0 && !mem_rd) begin
      mem_ack = 1'($urandom_range(0, 1)); mem_data = 8'($urandom);
    end else mem_ack = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int a, input int b);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'hFFFF);
    end else begin
      e = q.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk(kind == EV_CLR ? "hpos" : kind == EV_LAT ? "pixels" : "done_a", 32'(a), 32'(e.a));
      chk(kind == EV_CLR ? "palette" : kind == EV_LAT ? "wm" : "done_b", 32'(b), 32'(e.b));
    end
  endtask

  always @(posedge clk_sys) if (mclk0) begin
    #1;
    if (clear_hpos) clr_seen++;
    if (dl_done) done_seen++;
    if (mon_en) begin
      if (clear_hpos || latch_byte) chk("clr_latch_overlap", 32'(clear_hpos & latch_byte), 0);
      if (clear_hpos) pop_check(EV_CLR, int'(hpos), int'(PALETTE));
      if (latch_byte) pop_check(EV_LAT, int'(PIXELS), int'(WM));
      if (dl_done) pop_check(EV_DONE, 0, 0);
    end
  end

  task automatic next_strobe();
    do begin
      @(negedge clk_sys);
      #1;
    end while (!mclk0);
  endtask

  task automatic start(input logic [15:0] a, input logic with_abort);
    dl_addr = a;
    next_strobe();
    dl_start = 1; dl_abort = with_abort;
    next_strobe();
    dl_start = 0; dl_abort = 0;
    chk("busy_after_start", 32'(dl_busy), 1);
  endtask

  task automatic wait_done(input string name);
    int n, d0;
    n = 0; d0 = done_seen;
    while (done_seen == d0 && n < 20000) begin
      @(posedge clk_sys);
      n++;
    end
    repeat (6) next_strobe();
    chk({name, "_done_count"}, 32'(done_seen - d0), 1);
    chk({name, "_queue_empty"}, 32'(q.size()), 0);
    chk({name, "_idle"}, 32'(dl_busy), 0);
  endtask

  task automatic put(input int a, input logic [7:0] d);
    mem[16'(a)] = d;
  endtask

  task automatic push_lat(input int a);
    push(EV_LAT, int'(mem[16'(a)]), exp_wm);
  endtask

  initial begin
    int n, c0, d0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a + (a >> 8) * 3);
    // 4-byte object then end
    put(16'h1000, 8'h00); put(16'h1001, 8'h3C); put(16'h1002, 8'hA0); put(16'h1003, 8'h20);
    put(16'h1004, 8'h77); put(16'h1005, 8'h00);
    // 5-byte indirect object, two chars
    put(16'h2000, 8'h10); put(16'h2001, 8'h60); put(16'h2002, 8'h40); put(16'h2003, 8'hFE);
    put(16'h2004, 8'h50); put(16'h2005, 8'h00); put(16'h2006, 8'h00);
    put(16'h4010, 8'h33); put(16'h4011, 8'hFF);
    // 5-byte direct with WM=1 then 4-byte
    put(16'h3000, 8'h00); put(16'h3001, 8'hC0); put(16'h3002, 8'h50); put(16'h3003, 8'h3F);
    put(16'h3004, 8'h10); put(16'h3005, 8'h08); put(16'h3006, 8'h5E); put(16'h3007, 8'h51);
    put(16'h3008, 8'h30); put(16'h3009, 8'h00); put(16'h300A, 8'h00);
    // list crossing FFFF with graphics crossing FFFF
    put(16'hFFFE, 8'hFF); put(16'hFFFF, 8'h3E); put(16'h0000, 8'hFF); put(16'h0001, 8'h40);
    put(16'h0002, 8'h00); put(16'h0003, 8'h00);
    // object for abort
    put(16'h6000, 8'h00); put(16'h6001, 8'h3C); put(16'h6002, 8'h70); put(16'h6003, 8'h08);
    // MAX_OBJ+1 single-byte objects
    for (int k = 0; k <= 64; k++) begin
      put(16'h9000 + 4 * k, 8'(k)); put(16'h9001 + 4 * k, 8'h3F);
      put(16'h9002 + 4 * k, 8'hB0); put(16'h9003 + 4 * k, 8'(k));
    end
    put(16'h9104, 8'h00); put(16'h9105, 8'h00);

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_busy", 32'(dl_busy), 0);
    chk("rst_wm", 32'(WM), 0);
    chk("rst_pulses", 32'({latch_byte, clear_hpos, dl_done}), 0);
    @(negedge clk_sys);
    RESET_N = 1;

    // start and abort together in IDLE: start wins
    zone_offset = 2;
    push(EV_CLR, 8'h20, 1);
    for (int a = 16'hA200; a <= 16'hA203; a++) push_lat(a);
    push(EV_DONE, 0, 0);
    start(16'h1000, 1);
    wait_done("four_byte");

    zone_offset = 0; charbase = 8'h80; cwidth = 1;
    push(EV_CLR, 8'h50, 7);
    push_lat(16'h8033); push_lat(16'h8034); push_lat(16'h80FF); push_lat(16'h8000);
    push(EV_DONE, 0, 0);
    start(16'h2000, 0);
    wait_done("indirect");
    cwidth = 0;

    zone_offset = 1; exp_wm = 1;
    push(EV_CLR, 8'h10, 1);
    push_lat(16'h5100);
    push(EV_CLR, 8'h30, 2);
    push_lat(16'h5208); push_lat(16'h5209);
    push(EV_DONE, 0, 0);
    start(16'h3000, 0);
    wait_done("wm_sticky");
    chk("wm_hold", 32'(WM), 1);

    zone_offset = 0;
    push(EV_CLR, 8'h40, 1);
    push_lat(16'hFFFF); push_lat(16'h0000);
    push(EV_DONE, 0, 0);
    start(16'hFFFE, 0);
    wait_done("wrap");

    // abort while the third graphics read is stalled
    hold_addr = 17'h07002;
    push(EV_CLR, 8'h08, 1);
    push_lat(16'h7000); push_lat(16'h7001);
    push(EV_DONE, 0, 0);
    start(16'h6000, 0);
    n = 0;
    while (!(mem_rd && mem_addr == 16'h7002) && n < 5000) begin
      @(posedge clk_sys);
      n++;
    end
    chk("abort_reach_gfx3", 32'(mem_rd && mem_addr == 16'h7002), 1);
    next_strobe(); next_strobe();
    chk("abort_rd_held", 32'(mem_rd), 1);
    dl_abort = 1;
    next_strobe();
    dl_abort = 0;
    chk("abort_rd_drop", 32'(mem_rd), 0);
    wait_done("abort");
    hold_addr = 17'h10000;

    c0 = clr_seen;
    for (int k = 0; k < 64; k++) begin
      push(EV_CLR, k, 1);
      push_lat(16'hB000 + k);
    end
    push(EV_DONE, 0, 0);
    start(16'h9000, 0);
    wait_done("guard");
    chk("guard_clr_count", 32'(clr_seen - c0), 64);

    // asynchronous reset in the middle of a walk
    mon_en = 0;
    c0 = clr_seen;
    start(16'h9000, 0);
    n = 0;
    while (clr_seen < c0 + 3 && n < 5000) begin
      @(posedge clk_sys);
      n++;
    end
    chk("midlist_progress", 32'(clr_seen >= c0 + 3), 1);
    @(posedge clk_sys);
    #3;
    d0 = done_seen;
    RESET_N = 0;
    #1;
    chk("mid_rst_mem_rd", 32'(mem_rd), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_busy", 32'(dl_busy), 0);
    chk("mid_rst_wm", 32'(WM), 0);
    chk("mid_rst_hpos_pal", 32'({hpos, PALETTE, PIXELS}), 0);
    repeat (4) next_strobe();
    chk("mid_rst_no_done", 32'(done_seen - d0), 0);
    RESET_N = 1;
    mon_en = 1; exp_wm = 0;

    zone_offset = 2;
    push(EV_CLR, 8'h20, 1);
    for (int a = 16'hA200; a <= 16'hA203; a++) push_lat(a);
    push(EV_DONE, 0, 0);
    start(16'h1000, 0);
    wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
